shared_mem_copy_master: RTL and testbench
=========================================

# shared_mem_copy_master

Avalon-MM master that copies a block of 32-bit words from one region of the MPSoC shared on-chip memory to another, without involving a CPU. It sits on the system interconnect as a master that drives the shared memory's slave port, pipelines reads through a small FIFO, and writes the data back out. Processors or a control block start it over a simple start/done handshake.

## Interface
- MEM_WORDS, 49152: shared memory depth in words; also the bound for range checks.
- FIFO_DEPTH, 8: read-data FIFO depth in words (power of two, 2..64); also caps outstanding reads.
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  16  source word address; sampled with start.
- dst_addr  in  16  destination word address; sampled with start.
- length  in  16  word count; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  high with done when the request was rejected; held until the next accepted start.
- avm_address  out  18  byte address, equal to word address << 2.
- avm_read / avm_write  out  1  command strobes; never both high.
- avm_byteenable  out  4  constant 4'hF.
- avm_writedata  out  32  FIFO head word.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier; pipelined reads are allowed.

## Operation
- Reset values: busy, done, error, avm_read, avm_write = 0; avm_address and avm_writedata = 0. The FIFO and all counters are cleared.
- States: IDLE, CHECK, RUN, FINISH.
- IDLE: start=1 latches src, dst and len, clears error, and moves to CHECK.
- CHECK takes one cycle:
  - len==0: go to FINISH with error=0 and no bus traffic.
  - src+len > MEM_WORDS, or dst+len > MEM_WORDS (17-bit compare): go to FINISH with error=1 and no bus traffic.
  - Overlap with dst>src and dst<src+len: go to FINISH with error=1 and no bus traffic.
  - Otherwise go to RUN.
- RUN counters:
  - rd_left: reads still to issue.
  - wr_left: writes still to issue.
  - pending: reads accepted but not yet returned.
  - fifo_cnt: words held in the FIFO.
- RUN command choice (only when no command is currently held):
  - Write has priority when fifo_cnt>0.
  - Otherwise issue a read when rd_left>0 and pending+fifo_cnt < FIFO_DEPTH.
- A command and its address/data stay stable while avm_waitrequest=1. Acceptance is the cycle with the strobe high and waitrequest low.
- On read acceptance: src pointer +1, rd_left −1, pending +1.
- On write acceptance: dst pointer +1, wr_left −1, FIFO pop.
- On avm_readdatavalid: FIFO push, pending −1. This can coincide with a pop (fifo_cnt unchanged) and with an acceptance in the same cycle.
- readdatavalid in any state other than RUN is ignored.
- FIFO overflow is impossible by construction. A push into a full FIFO is a design error that the bench must assert on.
- wr_left==0 in RUN: go to FINISH.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- start outside IDLE is ignored.
- reset_n low at any point aborts the copy. The destination keeps whatever was already written, and in-flight read data is dropped.

## Timing
- start at edge N: busy=1 after edge N+1 (CHECK), first avm_read after edge N+2.
- Zero-wait slave, read latency 1: one word costs read, data, then write. The total for len words is at most 2·len+4 cycles from start to done.
- done rises in the cycle after the final write is accepted. busy falls in that same cycle.
- A rejected request or len==0: done two cycles after start, with no strobes.

## Configuration
- COPY_CHECKSUM_EN defined:
  - Adds output checksum[31:0], reset to 0 and cleared when start is accepted.
  - Each accepted write adds avm_writedata modulo 2^32.
  - The value is valid from done onward and held until the next accepted start.
- COPY_CHECKSUM_EN undefined: no checksum port and no adder.

## Test plan
- Zero-wait memory model, src=0x0000, dst=0x0100, len=4, source words 1,2,3,4 → words 0x100–0x103 = 1,2,3,4; done once; error=0; done within 12 cycles of start; checksum=10 when enabled.
- Random waitrequest (50%) and read latency 1–4, len=100, FIFO_DEPTH=8 → destination matches source; command signals stable under stall; pending+fifo_cnt never above 8.
- len=0 → done two cycles after start, error=0, no avm_read/avm_write.
- src=49150, len=4 → error=1 with done; no bus traffic. Also src=0x10, dst=0x12, len=4 (overlap) → error=1.
- reset_n pulsed low mid-copy of len=64 → all outputs 0 immediately; a following start with len=2 completes correctly.
- start held high for the whole copy → exactly one copy and one done pulse; the second copy starts only after return to IDLE.

Source files
------------

// File: rtl/shared_mem_copy_master_if.sv
// shared_mem_copy_master_if: control handshake and Avalon-MM master bus of
// the block copy engine. The master modport is the engine's view, the slave
// modport is the view of the controller/interconnect around it.
// Optional: COPY_CHECKSUM_EN adds the checksum output.
interface shared_mem_copy_master_if;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        error;
  logic [17:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
`ifdef COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  modport master (
    input  start, src_addr, dst_addr, length,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output busy, done, error,
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
`ifdef COPY_CHECKSUM_EN
    , output checksum
`endif
  );

  modport slave (
    output start, src_addr, dst_addr, length,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  busy, done, error,
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
`ifdef COPY_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/shared_mem_copy_master.sv
// shared_mem_copy_master: Avalon-MM master copying a block of 32-bit words
// between two regions of the shared memory. Reads are pipelined into a small
// FIFO; outstanding reads plus buffered words never exceed FIFO_DEPTH.
// Optional: COPY_CHECKSUM_EN adds a running modulo-2^32 sum of written words.
module shared_mem_copy_master #(
  parameter int MEM_WORDS  = 49152,
  parameter int FIFO_DEPTH = 8
) (
  input logic                      clk,
  input logic                      reset_n,
  shared_mem_copy_master_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = AW + 2;
  localparam logic [SW-1:0] DEPTH_C = SW'(FIFO_DEPTH);
  localparam logic [16:0]   MEM_C   = 17'(MEM_WORDS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:0]   src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [15:0]   rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic [CW-1:0] pending_q, pending_d, fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          read_q, read_d, write_q, write_d, error_q, error_d;
  logic [17:0]   addr_q, addr_d;
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic          fifo_we, acc_rd, acc_wr, rdv;
  logic [16:0]   sum_src, sum_dst;
`ifdef COPY_CHECKSUM_EN
  logic [31:0]   checksum_q, checksum_d;
  assign bus.checksum = checksum_q;
`endif

  assign acc_rd  = read_q  & ~bus.avm_waitrequest;
  assign acc_wr  = write_q & ~bus.avm_waitrequest;
  assign rdv     = bus.avm_readdatavalid & (state_q == S_RUN);
  assign sum_src = {1'b0, src_q} + {1'b0, len_q};
  assign sum_dst = {1'b0, dst_q} + {1'b0, len_q};

  assign bus.busy           = (state_q == S_CHECK) || (state_q == S_RUN);
  assign bus.done           = (state_q == S_FINISH);
  assign bus.error          = error_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_byteenable = 4'hF;
  assign bus.avm_writedata  = fifo_q[rptr_q];

  // Next-state logic: request checking, counter bookkeeping, command choice
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    rd_left_d  = rd_left_q;
    wr_left_d  = wr_left_q;
    pending_d  = pending_q;
    fifo_cnt_d = fifo_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    read_d     = read_q;
    write_d    = write_q;
    addr_d     = addr_q;
    error_d    = error_q;
    fifo_we    = 1'b0;
`ifdef COPY_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_d   = bus.src_addr;
          dst_d   = bus.dst_addr;
          len_d   = bus.length;
          error_d = 1'b0;
`ifdef COPY_CHECKSUM_EN
          checksum_d = '0;
`endif
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (len_q == '0) begin
          state_d = S_FINISH;
        end else if (sum_src > MEM_C || sum_dst > MEM_C ||
                     (dst_q > src_q && {1'b0, dst_q} < sum_src)) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          rd_left_d = len_q;
          wr_left_d = len_q;
          read_d    = 1'b1;
          addr_d    = {src_q, 2'b00};
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (acc_rd) begin
          src_d     = src_q + 16'd1;
          rd_left_d = rd_left_q - 16'd1;
        end
        if (acc_wr) begin
          dst_d     = dst_q + 16'd1;
          wr_left_d = wr_left_q - 16'd1;
          rptr_d    = rptr_q + AW'(1);
`ifdef COPY_CHECKSUM_EN
          checksum_d = checksum_q + bus.avm_writedata;
`endif
        end
        if (rdv) begin
          fifo_we = 1'b1;
          wptr_d  = wptr_q + AW'(1);
        end
        pending_d  = pending_q + CW'(acc_rd) - CW'(rdv);
        fifo_cnt_d = fifo_cnt_q + CW'(rdv) - CW'(acc_wr);
        // The next command is chosen from the post-update counters so an
        // accepted command can be followed back-to-back by the next one.
        if (acc_rd || acc_wr || (!read_q && !write_q)) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (fifo_cnt_d != '0) begin
            write_d = 1'b1;
            addr_d  = {dst_d, 2'b00};
          end else if (rd_left_d != '0 &&
                       ({1'b0, pending_d} + {1'b0, fifo_cnt_d}) < DEPTH_C) begin
            read_d = 1'b1;
            addr_d = {src_d, 2'b00};
          end
        end
        if (wr_left_d == '0) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = S_FINISH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      pending_q  <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      error_q    <= 1'b0;
`ifdef COPY_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      rd_left_q  <= rd_left_d;
      wr_left_q  <= wr_left_d;
      pending_q  <= pending_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      read_q     <= read_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      error_q    <= error_d;
`ifdef COPY_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  // Read-data FIFO storage; cleared on reset so writedata idles at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (fifo_we) begin
      fifo_q[wptr_q] <= bus.avm_readdata;
    end
  end
endmodule

// File: tb/tb_shared_mem_copy_master.sv
// Scoreboard bench for shared_mem_copy_master: a memory/slave model with
// optional random waitrequest and read latency, expected writes and
// completions queued at issue time and checked by a separate monitor.
module tb_shared_mem_copy_master;
  localparam int MEMW  = 49152;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shared_mem_copy_master_if bif ();
  shared_mem_copy_master #(.MEM_WORDS(MEMW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif));

  typedef struct { logic [17:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic err; int start_cyc; int exact; int max_lat; logic [31:0] csum; } done_t;
  typedef struct { int due; logic [31:0] data; } rd_t;

  wr_t         wr_q[$];
  logic [17:0] rdaddr_q[$];
  done_t       done_q[$];
  rd_t         rd_q[$];
  logic [31:0] mem [MEMW];

  int checks = 0, errors = 0;
  int cyc = 0;
  bit random_mode = 0;
  int outstanding = 0, last_due = 0, lat = 0;
  logic p_stall = 0, p_read = 0, p_write = 0;
  logic [17:0] p_addr = '0, a_tmp;
  logic [31:0] p_data = '0;
  rd_t r_tmp; wr_t w_tmp; done_t d_tmp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Slave model + monitor: everything sampled/driven at the falling edge
  initial begin
    bif.avm_waitrequest = 1'b0; bif.avm_readdatavalid = 1'b0; bif.avm_readdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_q.delete(); outstanding = 0; last_due = 0; p_stall = 0;
        bif.avm_waitrequest = 1'b0; bif.avm_readdatavalid = 1'b0;
        continue;
      end
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        r_tmp = rd_q.pop_front();
        bif.avm_readdatavalid = 1'b1; bif.avm_readdata = r_tmp.data;
      end else begin
        bif.avm_readdatavalid = 1'b0; bif.avm_readdata = $urandom;
      end
      if (p_stall)
        check("stall_hold", bif.avm_read == p_read && bif.avm_write == p_write &&
              bif.avm_address == p_addr && (!p_write || bif.avm_writedata == p_data),
              {bif.avm_read, bif.avm_write, bif.avm_address}, {p_read, p_write, p_addr});
      if (bif.avm_read || bif.avm_write)
        check("one_strobe", !(bif.avm_read && bif.avm_write), {bif.avm_read, bif.avm_write}, 0);
      bif.avm_waitrequest = random_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
      p_stall = (bif.avm_read || bif.avm_write) && bif.avm_waitrequest;
      p_read = bif.avm_read; p_write = bif.avm_write;
      p_addr = bif.avm_address; p_data = bif.avm_writedata;
      if (bif.avm_read && !bif.avm_waitrequest) begin
        check("read_expected", rdaddr_q.size() != 0, rdaddr_q.size(), 1);
        if (rdaddr_q.size() != 0) begin
          a_tmp = rdaddr_q.pop_front();
          check("read_addr", bif.avm_address == a_tmp, bif.avm_address, a_tmp);
        end
        lat = random_mode ? int'($urandom_range(1, 4)) : 1;
        r_tmp.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = r_tmp.due;
        r_tmp.data = mem[bif.avm_address[17:2]];
        rd_q.push_back(r_tmp);
        outstanding++;
        check("fifo_room", outstanding <= DEPTH, outstanding, DEPTH);
      end
      if (bif.avm_write && !bif.avm_waitrequest) begin
        check("write_expected", wr_q.size() != 0, wr_q.size(), 1);
        if (wr_q.size() != 0) begin
          w_tmp = wr_q.pop_front();
          check("write_addr", bif.avm_address == w_tmp.addr, bif.avm_address, w_tmp.addr);
          check("write_data", bif.avm_writedata == w_tmp.data, bif.avm_writedata, w_tmp.data);
        end
        if (int'(bif.avm_address[17:2]) < MEMW) mem[bif.avm_address[17:2]] = bif.avm_writedata;
        outstanding--;
      end
      if (bif.done) begin
        check("done_expected", done_q.size() != 0, done_q.size(), 1);
        if (done_q.size() != 0) begin
          d_tmp = done_q.pop_front();
          lat = cyc - d_tmp.start_cyc;
          check("error", bif.error == d_tmp.err, bif.error, d_tmp.err);
          check("busy_at_done", bif.busy == 1'b0, bif.busy, 0);
          check("all_written", wr_q.size() == 0 && rdaddr_q.size() == 0, wr_q.size(), 0);
          if (d_tmp.exact >= 0) check("done_latency", lat == d_tmp.exact, lat, d_tmp.exact);
          else check("done_bound", lat <= d_tmp.max_lat, lat, d_tmp.max_lat);
`ifdef COPY_CHECKSUM_EN
          check("checksum", bif.checksum == d_tmp.csum, bif.checksum, d_tmp.csum);
`endif
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  bif.busy == 1'b0, bif.busy, 0);
    check({tag, "_done"},  bif.done == 1'b0, bif.done, 0);
    check({tag, "_error"}, bif.error == 1'b0, bif.error, 0);
    check({tag, "_strobes"}, !bif.avm_read && !bif.avm_write, {bif.avm_read, bif.avm_write}, 0);
    check({tag, "_addr"},  bif.avm_address == '0, bif.avm_address, 0);
    check({tag, "_wdata"}, bif.avm_writedata == '0, bif.avm_writedata, 0);
    check({tag, "_be"},    bif.avm_byteenable == 4'hF, bif.avm_byteenable, 15);
`ifdef COPY_CHECKSUM_EN
    check({tag, "_csum"},  bif.checksum == '0, bif.checksum, 0);
`endif
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) mem[base + i] = $urandom;
  endtask

  // Reference model: decide the outcome from the request rules, queue the
  // expected reads/writes/completion, then raise start.
  task automatic issue(input int src, input int dst, input int len, input bit hold);
    bit bad;
    done_t d;
    wr_t w;
    logic [31:0] sum = '0;
    bad = (len != 0) && ((src + len > MEMW) || (dst + len > MEMW) ||
                         (dst > src && dst < src + len));
    if (len != 0 && !bad)
      for (int i = 0; i < len; i++) begin
        w.addr = 18'((dst + i) * 4);
        w.data = mem[src + i];
        sum += w.data;
        wr_q.push_back(w);
        rdaddr_q.push_back(18'((src + i) * 4));
      end
    d.err = bad;
    d.exact = (len == 0 || bad) ? 2 : -1;
    d.max_lat = random_mode ? 40 * len + 100 : 2 * len + 4;
    d.csum = sum;
    @(posedge clk); #1;
    bif.start = 1'b1;
    bif.src_addr = 16'(src); bif.dst_addr = 16'(dst); bif.length = 16'(len);
    d.start_cyc = cyc;
    done_q.push_back(d);
    @(posedge clk); #1;
    if (!hold) bif.start = 1'b0;
    check("busy_after_start", bif.busy == 1'b1, bif.busy, 1);
    @(posedge clk); #1;
    if (len != 0 && !bad)
      check("first_read", bif.avm_read && bif.avm_address == 18'(src * 4),
            {bif.avm_read, bif.avm_address}, {1'b1, 18'(src * 4)});
  endtask

  task automatic wait_done(input int budget, input bit hold);
    int n = 0;
    while (done_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_timeout", done_q.size() == 0, done_q.size(), 0);
    if (hold) bif.start = 1'b0;
    if (done_q.size() != 0) begin
      done_q.delete(); wr_q.delete(); rdaddr_q.delete();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int s, d, l;
    bif.start = 1'b0; bif.src_addr = '0; bif.dst_addr = '0; bif.length = '0;
    for (int i = 0; i < MEMW; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("por");
    reset_n = 1'b1;

    // Directed zero-wait copy of 1,2,3,4
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    issue(0, 'h100, 4, 0);
    wait_done(100, 0);
    for (int i = 0; i < 4; i++)
      check("dst_word", mem['h100 + i] == 32'(i + 1), mem['h100 + i], i + 1);

    // Empty, out-of-range and overlapping requests
    issue('h20, 'h200, 0, 0);      wait_done(20, 0);
    issue(49150, 'h200, 4, 0);     wait_done(20, 0);
    issue(0, 49150, 4, 0);         wait_done(20, 0);
    issue('h10, 'h12, 4, 0);       wait_done(20, 0);

    // Valid edge cases: range end, adjacency, backward overlap, self copy
    fill(49148, 4); issue(49148, 'h300, 4, 0); wait_done(100, 0);
    fill('h400, 3); issue('h400, 49149, 3, 0); wait_done(100, 0);
    fill('h500, 4); issue('h500, 'h504, 4, 0); wait_done(100, 0);
    fill('h640, 8); issue('h640, 'h63e, 8, 0); wait_done(100, 0);
    fill('h680, 5); issue('h680, 'h680, 5, 0); wait_done(100, 0);

    // Random stalls and read latency
    random_mode = 1;
    for (int k = 0; k < 4; k++) begin
      l = (k < 2) ? 100 : int'($urandom_range(1, 40));
      s = $urandom_range(0, 20000);
      d = $urandom_range(25000, 45000);
      if (k == 3) begin int t = s; s = d; d = t; end
      fill(s, l);
      issue(s, d, l, 0);
      wait_done(40 * l + 200, 0);
    end

    // Reset in the middle of a copy, then a short copy
    fill('h1000, 64);
    issue('h1000, 'h5000, 64, 0);
    repeat (40) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_zero("midrst");
    done_q.delete(); wr_q.delete(); rdaddr_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    random_mode = 0;
    fill('h6000, 2); issue('h6000, 'h6100, 2, 0); wait_done(100, 0);

    // Start held through the whole copy: only one copy and one done
    fill('h700, 6); issue('h700, 'h800, 6, 1); wait_done(100, 1);
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
